// File: rtl/tick_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tick_timer_scheduler
//
// Multi-channel software-timer scheduler. A single shared decrement unit walks
// the channels one per clock after every divider tick. Each channel counts
// down in ticks and raises a one-cycle expiry pulse when it reaches the end of
// its period. It then either reloads (periodic) or stops (one-shot). When no
// channel is running, the divider is frozen through o_div_stop.
//
// Ports:
//   i_clk          clock
//   i_rst          synchronous, active-high reset
//   i_tick         one-cycle pulse from the divider output
//   o_div_stop     divider stop request; 1 when no channel is active
//   i_cmd_valid    command request
//   o_cmd_ready    command accepted on valid & ready (high only while idle)
//   i_cmd_op       00 start periodic, 01 start one-shot, 10 stop, 11 restart
//   i_cmd_ch       target channel
//   i_cmd_period   period in ticks (start ops only)
//   o_expire       one-cycle expiry pulse per channel
//   o_active       per-channel running flags
//   o_err          one-cycle pulse on a rejected command
//   o_overrun      one-cycle pulse when a tick is dropped
// -----------------------------------------------------------------------------
module tick_timer_scheduler #(
    parameter  int p_channels = 4,
    parameter  int p_width    = 16,
    localparam int lp_chw     = (p_channels > 1) ? $clog2(p_channels) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tick,
    output logic                  o_div_stop,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [lp_chw-1:0]     i_cmd_ch,
    input  logic [p_width-1:0]    i_cmd_period,
    output logic [p_channels-1:0] o_expire,
    output logic [p_channels-1:0] o_active,
    output logic                  o_err,
    output logic                  o_overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [lp_chw-1:0] lp_last_slot = lp_chw'(p_channels - 1);
    // One bit wider than the channel index so that a power-of-two channel
    // count is still representable for the range check.
    localparam logic [lp_chw:0]   lp_num_ch    = (lp_chw + 1)'(p_channels);
    localparam logic [p_width-1:0] lp_one      = p_width'(1);

    // Scheduler control
    state_t              state_q, state_n;
    logic [lp_chw-1:0]   slot_q,  slot_n;
    logic                pend_q,  pend_n;

    // Per-channel timer state
    logic [p_width-1:0]    period_q [p_channels];
    logic [p_width-1:0]    period_n [p_channels];
    logic [p_width-1:0]    count_q  [p_channels];
    logic [p_width-1:0]    count_n  [p_channels];
    logic [p_channels-1:0] mode_q,   mode_n;
    logic [p_channels-1:0] active_q, active_n;
    logic [p_channels-1:0] fresh_q,  fresh_n;

    // Registered outputs
    logic [p_channels-1:0] expire_q, expire_n;
    logic                  err_q,    err_n;
    logic                  ovr_q,    ovr_n;
    logic                  dstop_q,  dstop_n;

    logic                  cmd_fire;
    logic                  ch_ok;
    logic [p_width-1:0]    sel_period;

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign cmd_fire    = i_cmd_valid && (state_q == ST_IDLE);
    assign ch_ok       = ({1'b0, i_cmd_ch} < lp_num_ch);

    assign o_expire    = expire_q;
    assign o_active    = active_q;
    assign o_err       = err_q;
    assign o_overrun   = ovr_q;
    assign o_div_stop  = dstop_q;

    // ---- next-state: scan sequencing, slot execution, command decode ----
    always_comb begin
        state_n    = state_q;
        slot_n     = slot_q;
        pend_n     = pend_q;
        period_n   = period_q;
        count_n    = count_q;
        mode_n     = mode_q;
        active_n   = active_q;
        fresh_n    = fresh_q;
        expire_n   = '0;
        err_n      = 1'b0;
        ovr_n      = 1'b0;
        sel_period = '0;

        for (int i = 0; i < p_channels; i++) begin
            if (i_cmd_ch == lp_chw'(i)) begin
                sel_period = period_q[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (i_tick) begin
                    state_n = ST_SCAN;
                    slot_n  = '0;
                end
            end

            ST_SCAN: begin
                // Service the channel owned by the current slot. Fresh
                // channels were (re)started on the tick that launched this
                // scan, so that tick must not count against them.
                for (int i = 0; i < p_channels; i++) begin
                    if (slot_q == lp_chw'(i) && active_q[i] && !fresh_q[i]) begin
                        if (count_q[i] == lp_one) begin
                            expire_n[i] = 1'b1;
                            if (mode_q[i]) begin
                                active_n[i] = 1'b0;
                                count_n[i]  = '0;
                            end else begin
                                count_n[i]  = period_q[i];
                            end
                        end else if (count_q[i] != '0) begin
                            count_n[i] = count_q[i] - lp_one;
                        end
                    end
                end

                if (slot_q == lp_last_slot) begin
                    fresh_n = '0;
                    slot_n  = '0;
                    if (pend_q) begin
                        // Pending tick consumes this restart; a tick landing
                        // in the same cycle finds the pending slot still full.
                        pend_n = 1'b0;
                        ovr_n  = i_tick;
                    end else if (!i_tick) begin
                        state_n = ST_IDLE;
                    end
                    // A tick on the last slot with nothing pending restarts
                    // immediately, which keeps the tick-to-slot-0 latency at 1.
                end else begin
                    slot_n = slot_q + lp_chw'(1);
                    if (i_tick) begin
                        if (pend_q) begin
                            ovr_n = 1'b1;
                        end else begin
                            pend_n = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (cmd_fire) begin
            case (i_cmd_op)
                2'b00, 2'b01: begin
                    if (!ch_ok || i_cmd_period == '0) begin
                        err_n = 1'b1;
                    end else begin
                        for (int i = 0; i < p_channels; i++) begin
                            if (i_cmd_ch == lp_chw'(i)) begin
                                period_n[i] = i_cmd_period;
                                count_n[i]  = i_cmd_period;
                                mode_n[i]   = i_cmd_op[0];
                                active_n[i] = 1'b1;
                                fresh_n[i]  = i_tick;
                            end
                        end
                    end
                end

                2'b10: begin
                    if (!ch_ok) begin
                        err_n = 1'b1;
                    end else begin
                        for (int i = 0; i < p_channels; i++) begin
                            if (i_cmd_ch == lp_chw'(i)) begin
                                active_n[i] = 1'b0;
                            end
                        end
                    end
                end

                default: begin
                    if (!ch_ok || sel_period == '0) begin
                        err_n = 1'b1;
                    end else begin
                        for (int i = 0; i < p_channels; i++) begin
                            if (i_cmd_ch == lp_chw'(i)) begin
                                count_n[i]  = period_q[i];
                                active_n[i] = 1'b1;
                                fresh_n[i]  = i_tick;
                            end
                        end
                    end
                end
            endcase
        end

        dstop_n = ~|active_n;
    end

    // ---- state register ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            pend_q   <= 1'b0;
            mode_q   <= '0;
            active_q <= '0;
            fresh_q  <= '0;
            expire_q <= '0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
            dstop_q  <= 1'b1;
            for (int i = 0; i < p_channels; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_n;
            slot_q   <= slot_n;
            pend_q   <= pend_n;
            mode_q   <= mode_n;
            active_q <= active_n;
            fresh_q  <= fresh_n;
            expire_q <= expire_n;
            err_q    <= err_n;
            ovr_q    <= ovr_n;
            dstop_q  <= dstop_n;
            for (int i = 0; i < p_channels; i++) begin
                period_q[i] <= period_n[i];
                count_q[i]  <= count_n[i];
            end
        end
    end

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_timer_scheduler
//
// Directed bench for tick_timer_scheduler. The main instance uses 4 channels;
// a second 3-channel instance exercises the out-of-range channel index, which
// a power-of-two channel count cannot express.
// -----------------------------------------------------------------------------
module tb_tick_timer_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_tick;
    logic        i_cmd_valid;
    logic [1:0]  i_cmd_op;
    logic [1:0]  i_cmd_ch;
    logic [15:0] i_cmd_period;
    logic        o_div_stop;
    logic        o_cmd_ready;
    logic [3:0]  o_expire;
    logic [3:0]  o_active;
    logic        o_err;
    logic        o_overrun;

    logic        t1_tick;
    logic        t1_cmd_valid;
    logic [1:0]  t1_cmd_op;
    logic [1:0]  t1_cmd_ch;
    logic [7:0]  t1_cmd_period;
    logic        t1_div_stop;
    logic        t1_cmd_ready;
    logic [2:0]  t1_expire;
    logic [2:0]  t1_active;
    logic        t1_err;
    logic        t1_overrun;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    tick_timer_scheduler #(.p_channels(4), .p_width(16)) u_dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick       (i_tick),
        .o_div_stop   (o_div_stop),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_op     (i_cmd_op),
        .i_cmd_ch     (i_cmd_ch),
        .i_cmd_period (i_cmd_period),
        .o_expire     (o_expire),
        .o_active     (o_active),
        .o_err        (o_err),
        .o_overrun    (o_overrun)
    );

    tick_timer_scheduler #(.p_channels(3), .p_width(8)) u_dut3 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tick       (t1_tick),
        .o_div_stop   (t1_div_stop),
        .i_cmd_valid  (t1_cmd_valid),
        .o_cmd_ready  (t1_cmd_ready),
        .i_cmd_op     (t1_cmd_op),
        .i_cmd_ch     (t1_cmd_ch),
        .i_cmd_period (t1_cmd_period),
        .o_expire     (t1_expire),
        .o_active     (t1_active),
        .o_err        (t1_err),
        .o_overrun    (t1_overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic tick();
        i_tick = 1'b1;
        step();
        i_tick = 1'b0;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] per);
        i_cmd_valid  = 1'b1;
        i_cmd_op     = op;
        i_cmd_ch     = ch;
        i_cmd_period = per;
        step();
        i_cmd_valid  = 1'b0;
    endtask

    task automatic cmd3(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] per);
        t1_cmd_valid  = 1'b1;
        t1_cmd_op     = op;
        t1_cmd_ch     = ch;
        t1_cmd_period = per;
        step();
        t1_cmd_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_tick = 1'b0; i_cmd_valid = 1'b0;
        i_cmd_op = 2'b00; i_cmd_ch = 2'd0; i_cmd_period = 16'd0;
        t1_tick = 1'b0; t1_cmd_valid = 1'b0;
        t1_cmd_op = 2'b00; t1_cmd_ch = 2'd0; t1_cmd_period = 8'd0;
        idle(3);

        // Reset state
        check_eq("rst_active",   32'(o_active),    32'h0);
        check_eq("rst_div_stop", 32'(o_div_stop),  32'h1);
        check_eq("rst_ready",    32'(o_cmd_ready), 32'h1);
        check_eq("rst_expire",   32'(o_expire),    32'h0);
        check_eq("rst_err",      32'(o_err),       32'h0);
        check_eq("rst_overrun",  32'(o_overrun),   32'h0);
        i_rst = 1'b0;
        step();

        // ch0 periodic P=3, nine ticks 10 cycles apart
        cmd(2'b00, 2'd0, 16'd3);
        check_eq("A_active",   32'(o_active),   32'h1);
        check_eq("A_div_stop", 32'(o_div_stop), 32'h0);
        idle(4);
        for (int n = 1; n <= 9; n++) begin
            tick();
            check_eq($sformatf("A_t%0d_T+1", n), 32'(o_expire), 32'h0);
            step();
            check_eq($sformatf("A_t%0d_T+2", n), 32'(o_expire), (n % 3 == 0) ? 32'h1 : 32'h0);
            idle(8);
        end

        // One more tick leaves ch0 at count 2, then stop it
        tick();
        idle(5);
        cmd(2'b10, 2'd0, 16'd0);
        check_eq("stop_active",   32'(o_active),   32'h0);
        check_eq("stop_div_stop", 32'(o_div_stop), 32'h1);

        // ch2 one-shot P=2
        cmd(2'b01, 2'd2, 16'd2);
        check_eq("B_active", 32'(o_active), 32'h4);
        idle(3);
        tick();
        idle(3);
        check_eq("B_t1_T+4", 32'(o_expire), 32'h0);
        idle(6);
        tick();
        idle(2);
        check_eq("B_t2_T+3", 32'(o_expire), 32'h0);
        step();
        check_eq("B_t2_T+4", 32'(o_expire), 32'h4);
        step();
        check_eq("B_t2_T+5_exp",  32'(o_expire),   32'h0);
        check_eq("B_active_off",  32'(o_active),   32'h0);
        check_eq("B_div_stop",    32'(o_div_stop), 32'h1);
        idle(4);

        // Rejected commands
        cmd(2'b00, 2'd1, 16'd0);
        check_eq("C_zero_period_err", 32'(o_err), 32'h1);
        step();
        check_eq("C_err_clear", 32'(o_err), 32'h0);
        cmd(2'b11, 2'd1, 16'd0);
        check_eq("C_restart_unloaded_err", 32'(o_err),    32'h1);
        check_eq("C_active_same",          32'(o_active), 32'h0);
        cmd(2'b10, 2'd3, 16'd0);
        check_eq("C_stop_inactive_noerr",  32'(o_err),    32'h0);
        cmd3(2'b00, 2'd3, 8'd5);
        check_eq("C_ch_range_err",    32'(t1_err),    32'h1);
        check_eq("C_ch_range_active", 32'(t1_active), 32'h0);
        cmd3(2'b00, 2'd2, 8'd5);
        check_eq("C_ch_ok_noerr",  32'(t1_err),    32'h0);
        check_eq("C_ch_ok_active", 32'(t1_active), 32'h4);
        idle(2);

        // Restart ch0 (held count 2) -> reloads to 3, expires on 3rd tick
        cmd(2'b11, 2'd0, 16'd0);
        check_eq("D_active", 32'(o_active), 32'h1);
        check_eq("D_err",    32'(o_err),    32'h0);
        idle(4);
        for (int n = 1; n <= 3; n++) begin
            tick();
            step();
            check_eq($sformatf("D_t%0d_T+2", n), 32'(o_expire), (n == 3) ? 32'h1 : 32'h0);
            idle(8);
        end

        // ch1 P=2 started on a tick: that tick is not counted
        i_tick = 1'b1;
        cmd(2'b00, 2'd1, 16'd2);
        i_tick = 1'b0;
        idle(2);
        check_eq("E_t0_T+3", 32'(o_expire), 32'h0);
        idle(7);
        tick();
        step();
        check_eq("E_t1_T+2", 32'(o_expire), 32'h0);
        step();
        check_eq("E_t1_T+3", 32'(o_expire), 32'h0);
        idle(7);
        tick();
        step();
        check_eq("E_t2_T+2", 32'(o_expire), 32'h1);
        step();
        check_eq("E_t2_T+3", 32'(o_expire), 32'h2);
        check_eq("E_active", 32'(o_active), 32'h3);
        idle(7);

        // Ticks at T0, T0+2, T0+3 with only ch3 (P=1) running
        cmd(2'b10, 2'd0, 16'd0);
        cmd(2'b10, 2'd1, 16'd0);
        cmd(2'b00, 2'd3, 16'd1);
        check_eq("F_active", 32'(o_active), 32'h8);
        idle(2);
        tick();                                  // now T0+1
        check_eq("F_ready_scan", 32'(o_cmd_ready), 32'h0);
        step();                                  // T0+2
        i_tick = 1'b1;
        step();                                  // T0+3 (tick T0+2 goes pending)
        check_eq("F_no_ovr_pending", 32'(o_overrun), 32'h0);
        step();                                  // T0+4 (tick T0+3 dropped)
        i_tick = 1'b0;
        check_eq("F_overrun", 32'(o_overrun), 32'h1);
        step();                                  // T0+5
        check_eq("F_ovr_clear",  32'(o_overrun),   32'h0);
        check_eq("F_exp_scan1",  32'(o_expire),    32'h8);
        check_eq("F_ready_b2b",  32'(o_cmd_ready), 32'h0);
        idle(2);                                 // T0+7
        check_eq("F_exp_mid",    32'(o_expire),    32'h0);
        idle(2);                                 // T0+9
        check_eq("F_exp_scan2",  32'(o_expire),    32'h8);
        check_eq("F_ready_idle", 32'(o_cmd_ready), 32'h1);
        idle(4);

        // Reset during the slot that would expire ch3
        tick();
        idle(3);                                 // T+4: slot 3 executing
        i_rst = 1'b1;
        step();
        check_eq("G_expire",   32'(o_expire),    32'h0);
        check_eq("G_active",   32'(o_active),    32'h0);
        check_eq("G_div_stop", 32'(o_div_stop),  32'h1);
        check_eq("G_ready",    32'(o_cmd_ready), 32'h1);
        check_eq("G_err",      32'(o_err),       32'h0);
        check_eq("G_overrun",  32'(o_overrun),   32'h0);
        i_rst = 1'b0;
        step();
        check_eq("G_expire_after", 32'(o_expire), 32'h0);
        cmd(2'b11, 2'd3, 16'd0);
        check_eq("G_period_cleared_err", 32'(o_err), 32'h1);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
